// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, access sizes,
// FSM state encoding and op/alignment helper functions.
package lsu_pkg;

    // Access op codes: bit 3 = store, bit 2 = unsigned load, bits 1:0 = size.
    localparam logic [3:0] OP_LB  = 4'h0;
    localparam logic [3:0] OP_LH  = 4'h1;
    localparam logic [3:0] OP_LW  = 4'h2;
    localparam logic [3:0] OP_LBU = 4'h4;
    localparam logic [3:0] OP_LHU = 4'h5;
    localparam logic [3:0] OP_SB  = 4'h8;
    localparam logic [3:0] OP_SH  = 4'h9;
    localparam logic [3:0] OP_SW  = 4'hA;

    // Size field encoding (op[1:0]).
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // True for the eight defined access kinds.
    function automatic logic lsu_op_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: lsu_op_legal = 1'b1;
            default:             lsu_op_legal = 1'b0;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned address.
    function automatic logic lsu_misaligned(input logic [3:0] op, input logic [1:0] lane);
        case (op[1:0])
            SIZE_H:  lsu_misaligned = lane[0];
            SIZE_W:  lsu_misaligned = (lane != 2'd0);
            default: lsu_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Word-organised data memory port with req/ack handshake and byte enables.
interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store replication and byte enables on the way out,
// lane extraction plus sign/zero extension on the way back.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store data replication and byte enables; loads always read the full word.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        if (op[3]) begin
            case (op[1:0])
                SIZE_B: begin
                    be        = 4'b0001 << lane;
                    wdata_rep = {4{wdata[7:0]}};
                end
                SIZE_H: begin
                    be        = 4'b0011 << lane;
                    wdata_rep = {2{wdata[15:0]}};
                end
                default: begin
                    be        = 4'b1111;
                    wdata_rep = wdata;
                end
            endcase
        end else begin
            be        = 4'b1111;
            wdata_rep = wdata;
        end
    end

    // Select the addressed byte/halfword and extend it per op[2].
    always_comb begin
        case (lane)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (lane[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (op[1:0])
            SIZE_B:  load_data = op[2] ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
            SIZE_H:  load_data = op[2] ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store unit: one access at a time from execute, req/ack
// memory port, registered results and a bounded wait for the memory ack.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        bus_err,
    lsu_mem_if.master   mem
);

    // Counter value seen in the last permitted wait cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [29:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [3:0]  align_op_s;
    logic [1:0]  align_lane_s;
    logic [3:0]  align_be_s;
    logic [31:0] align_wdata_s;
    logic [31:0] align_load_s;

    // The aligner sees the incoming request while idle (store path) and the
    // latched access afterwards (load path), so one instance serves both.
    always_comb begin
        if (state_q == ST_IDLE) begin
            align_op_s   = op;
            align_lane_s = addr[1:0];
        end else begin
            align_op_s   = op_q;
            align_lane_s = lane_q;
        end
    end

    lsu_lane_align u_align (
        .op        (align_op_s),
        .lane      (align_lane_s),
        .wdata     (wdata),
        .rdata     (mem.mem_rdata),
        .be        (align_be_s),
        .wdata_rep (align_wdata_s),
        .load_data (align_load_s)
    );

    // Next-state and registered-output logic of the access FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        lane_d      = lane_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        bus_err_d   = 1'b0;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = op;
                    lane_d = addr[1:0];
                    busy_d = 1'b1;
                    if (!lsu_op_legal(op) || lsu_misaligned(op, addr[1:0])) begin
                        // Rejected before any memory traffic.
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        cnt_d       = 8'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = op[3];
                        mem_addr_d  = addr[31:2];
                        mem_be_d    = align_be_s;
                        mem_wdata_d = align_wdata_s;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (mem.mem_ack) begin
                    // Ack wins even in the last wait cycle.
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                    done_d    = 1'b1;
                    if (!op_q[3]) begin
                        rdata_d = align_load_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            op_q        <= 4'h0;
            lane_q      <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            rdata_q     <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 30'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            bus_err_q   <= bus_err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign fault         = fault_q;
    assign bus_err       = bus_err_q;
    assign rdata         = rdata_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses
// plus a hand-written reset-during-access sequence.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    lsu_mem_if mem_bus ();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .rdata   (rdata),
        .fault   (fault),
        .bus_err (bus_err),
        .mem     (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;      // word returned by memory
        int          ack_cyc;  // cycle in which ack is given, 0 = never
        int          done_cyc; // expected cycle of done
        logic        fault;
        logic        berr;
        logic [3:0]  be;
        logic [31:0] mwdata;   // expected mem_wdata (stores only)
        logic [31:0] rdata;    // expected rdata after done
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Apply one access starting at the current negedge; returns one negedge
    // into the cycle after done.
    task automatic run_vec(input vec_t v, input int idx);
        int dc;
        dc    = 0;
        start = 1'b1;
        op    = v.op;
        addr  = v.addr;
        wdata = v.wdata;
        @(posedge clk);
        for (int c = 1; c <= 12 && dc == 0; c++) begin
            @(negedge clk);
            start           = 1'b0;
            mem_bus.mem_ack = 1'b0;
            if (c == 1) begin
                chk("req_c1", idx, 32'(mem_bus.mem_req), 32'(!v.fault));
                chk("busy_c1", idx, 32'(busy), 32'd1);
                if (!v.fault) begin
                    chk("we", idx, 32'(mem_bus.mem_we), 32'(v.op[3]));
                    chk("maddr", idx, 32'(mem_bus.mem_addr), 32'(v.addr[31:2]));
                    chk("be", idx, 32'(mem_bus.mem_be), 32'(v.be));
                    if (v.op[3]) begin
                        chk("mwdata", idx, mem_bus.mem_wdata, v.mwdata);
                    end
                end
            end
            if (done) begin
                dc = c;
                chk("fault", idx, 32'(fault), 32'(v.fault));
                chk("bus_err", idx, 32'(bus_err), 32'(v.berr));
                chk("rdata", idx, rdata, v.rdata);
                chk("busy_done", idx, 32'(busy), 32'd1);
                chk("req_done", idx, 32'(mem_bus.mem_req), 32'd0);
            end else if (c > 1) begin
                chk("req_wait", idx, 32'(mem_bus.mem_req), 32'd1);
            end
            if (c == v.ack_cyc) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = v.mrd;
            end
            @(posedge clk);
        end
        chk("done_cycle", idx, 32'(dc), 32'(v.done_cyc));
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        chk("done_pulse", idx, 32'(done), 32'd0);
        chk("busy_after", idx, 32'(busy), 32'd0);
    endtask

    initial begin
        //           op     addr          wdata         mrd           ack dn flt ber be       mwdata        rdata
        tbl[0]  = '{4'hA, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1, 2, 1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[1]  = '{4'h0, 32'h0000_0013, 32'h0000_0000, 32'h80FF_0102, 1, 2, 1'b0, 1'b0, 4'b1111, 32'h0000_0000, 32'hFFFF_FF80};
        tbl[2]  = '{4'h4, 32'h0000_0013, 32'h0000_0000, 32'h80FF_0102, 2, 3, 1'b0, 1'b0, 4'b1111, 32'h0000_0000, 32'h0000_0080};
        tbl[3]  = '{4'h1, 32'h0000_0012, 32'h0000_0000, 32'h8001_ABCD, 1, 2, 1'b0, 1'b0, 4'b1111, 32'h0000_0000, 32'hFFFF_8001};
        tbl[4]  = '{4'h9, 32'h0000_0012, 32'h0000_1234, 32'h0000_0000, 1, 2, 1'b0, 1'b0, 4'b1100, 32'h1234_1234, 32'hFFFF_8001};
        tbl[5]  = '{4'h2, 32'h0000_0011, 32'h0000_0000, 32'h0000_0000, 0, 1, 1'b1, 1'b0, 4'b1111, 32'h0000_0000, 32'hFFFF_8001};
        tbl[6]  = '{4'h3, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 0, 1, 1'b1, 1'b0, 4'b1111, 32'h0000_0000, 32'hFFFF_8001};
        tbl[7]  = '{4'h2, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 0, 5, 1'b0, 1'b1, 4'b1111, 32'h0000_0000, 32'hFFFF_8001};
        tbl[8]  = '{4'h2, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678, 4, 5, 1'b0, 1'b0, 4'b1111, 32'h0000_0000, 32'h1234_5678};
        tbl[9]  = '{4'h5, 32'h0000_0016, 32'h0000_0000, 32'hFEDC_0000, 3, 4, 1'b0, 1'b0, 4'b1111, 32'h0000_0000, 32'h0000_FEDC};
        tbl[10] = '{4'h8, 32'h0000_000D, 32'h0000_00A5, 32'h0000_0000, 1, 2, 1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_FEDC};
        tbl[11] = '{4'h1, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 0, 1, 1'b1, 1'b0, 4'b1111, 32'h0000_0000, 32'h0000_FEDC};
        tbl[12] = '{4'h0, 32'h0000_0001, 32'h0000_0000, 32'h0000_7F00, 2, 3, 1'b0, 1'b0, 4'b1111, 32'h0000_0000, 32'h0000_007F};
        tbl[13] = '{4'hA, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 0, 1, 1'b1, 1'b0, 4'b1111, 32'h0000_0000, 32'h0000_007F};
        tbl[14] = '{4'hF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 1, 1'b1, 1'b0, 4'b1111, 32'h0000_0000, 32'h0000_007F};

        reset             = 1'b1;
        start             = 1'b0;
        op                = 4'h0;
        addr              = 32'd0;
        wdata             = 32'd0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state.
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        chk("rst_rdata", 0, rdata, 32'd0);
        chk("rst_fault", 0, 32'(fault), 32'd0);
        chk("rst_bus_err", 0, 32'(bus_err), 32'd0);
        chk("rst_req", 0, 32'(mem_bus.mem_req), 32'd0);
        chk("rst_we", 0, 32'(mem_bus.mem_we), 32'd0);
        chk("rst_maddr", 0, 32'(mem_bus.mem_addr), 32'd0);
        chk("rst_be", 0, 32'(mem_bus.mem_be), 32'd0);
        chk("rst_mwdata", 0, mem_bus.mem_wdata, 32'd0);
        reset = 1'b0;

        // Table vectors, issued back-to-back.
        for (int i = 0; i < 15; i++) begin
            run_vec(tbl[i], i);
        end

        // Reset in cycle 2 of a pending load, then a normal access in cycle 3.
        start = 1'b1;
        op    = 4'h2;
        addr  = 32'h0000_0040;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("mr_req_c1", 100, 32'(mem_bus.mem_req), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("mr_req_c2", 100, 32'(mem_bus.mem_req), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mr_req_c3", 100, 32'(mem_bus.mem_req), 32'd0);
        chk("mr_busy_c3", 100, 32'(busy), 32'd0);
        chk("mr_rdata_c3", 100, rdata, 32'd0);
        reset = 1'b0;
        start = 1'b1;
        op    = 4'h4;
        addr  = 32'h0000_0041;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("mr_req_c4", 100, 32'(mem_bus.mem_req), 32'd1);
        chk("mr_busy_c4", 100, 32'(busy), 32'd1);
        chk("mr_maddr_c4", 100, 32'(mem_bus.mem_addr), 32'h0000_0010);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h0000_C300;
        @(posedge clk);
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        chk("mr_done_c5", 100, 32'(done), 32'd1);
        chk("mr_rdata_c5", 100, rdata, 32'h0000_00C3);
        chk("mr_fault_c5", 100, 32'(fault), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("mr_busy_c6", 100, 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
